btn_conditioner: RTL and testbench

Parametrised N-channel input conditioner for board buttons and mouse button levels, replacing the fixed 4-sample debounce and single-channel onepulse pair used in the display top. Each channel gets a 2-flop synchroniser, a counter-based debounce of configurable length, optional polarity inversion, and registered rise/fall pulses. It sits between raw pads or PS/2 button levels and the editor, recogniser and VGA control logic.

---
 rtl/btn_conditioner_pkg.sv | 27 ++
 rtl/btn_channel.sv | 122 ++++++++++++
 rtl/btn_conditioner.sv | 50 +++++
 tb/tb_btn_conditioner.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/btn_conditioner_pkg.sv
// Shared constants and counter-width helpers for the button conditioner.
// Auto-repeat support is compiled in only when BTN_CONDITIONER_AUTOREPEAT_EN
// is defined; the HOLD/REPEAT defaults below are sized for a 100 MHz clk.
package btn_conditioner_pkg;

  localparam int unsigned DB_CYCLES_DEFAULT     = 16;
  localparam int unsigned HOLD_CYCLES_DEFAULT   = 50_000_000;  // 0.5 s
  localparam int unsigned REPEAT_CYCLES_DEFAULT = 10_000_000;  // 0.1 s

  // Debounce counter must hold 0..DB_CYCLES.
  function automatic int unsigned db_cnt_w(input int unsigned db_cycles);
    int unsigned w;
    w = $clog2(db_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

  // Hold counter must hold 0..max(HOLD, REPEAT).
  function automatic int unsigned hold_cnt_w(input int unsigned hold_cycles,
                                             input int unsigned repeat_cycles);
    int unsigned m;
    int unsigned w;
    m = (hold_cycles > repeat_cycles) ? hold_cycles : repeat_cycles;
    w = $clog2(m + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// Single button channel: polarity fix, 2-flop synchroniser, counter debounce,
// rise/fall pulse generation and, with BTN_CONDITIONER_AUTOREPEAT_EN defined,
// long-press detection with periodic auto-repeat pulses on press_o.
module btn_channel
  import btn_conditioner_pkg::*;
#(
  parameter int unsigned DB_CYCLES  = DB_CYCLES_DEFAULT,
  parameter bit          ACTIVE_LOW = 1'b0
`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
  ,
  parameter int unsigned HOLD_CYCLES   = HOLD_CYCLES_DEFAULT,
  parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEFAULT
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic in_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic press_o,
  output logic held_o
);

  localparam int unsigned DBW = db_cnt_w(DB_CYCLES);
  typedef logic [DBW-1:0] db_cnt_t;
  localparam db_cnt_t DB_LAST = db_cnt_t'(DB_CYCLES - 1);

  logic    s1_q, s2_q;
  logic    level_q, level_d;
  logic    level_dly_q;
  db_cnt_t cnt_q, cnt_d;

  // Debounce: accept s2 only after DB_CYCLES consecutive disagreeing samples;
  // any agreeing sample throws the partial count away.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (s2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == DB_LAST) begin
      level_d = s2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + db_cnt_t'(1);
    end
  end

  // Synchroniser, debounce state and one-cycle-delayed level for edge pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      s1_q        <= in_i ^ ACTIVE_LOW;
      s2_q        <= s1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      cnt_q       <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = level_q & ~level_dly_q;
  assign fall_o  = ~level_q & level_dly_q;

`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
  localparam int unsigned HW = hold_cnt_w(HOLD_CYCLES, REPEAT_CYCLES);
  typedef logic [HW-1:0] hold_cnt_t;
  localparam hold_cnt_t HOLD_TC = hold_cnt_t'(HOLD_CYCLES);
  // Reloading to HOLD-REPEAT makes every later repeat land REPEAT cycles apart.
  localparam hold_cnt_t RELOAD  = hold_cnt_t'(HOLD_CYCLES - REPEAT_CYCLES);

  hold_cnt_t hold_q, hold_d, hold_inc;
  logic      rep_q, rep_d;
  logic      held_q, held_d;

  // Hold timer keyed on the next level so held/repeat drop in the fall cycle
  // and the repeat pulse can never share a cycle with rise.
  always_comb begin
    hold_d   = hold_q;
    rep_d    = 1'b0;
    held_d   = held_q;
    hold_inc = hold_q + hold_cnt_t'(1);
    if (!level_d) begin
      hold_d = '0;
      held_d = 1'b0;
    end else if (!level_q) begin
      hold_d = '0;
    end else if (hold_inc == HOLD_TC) begin
      rep_d  = 1'b1;
      held_d = 1'b1;
      hold_d = RELOAD;
    end else begin
      hold_d = hold_inc;
    end
  end

  // Hold timer, repeat pulse and long-press flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
      rep_q  <= 1'b0;
      held_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      rep_q  <= rep_d;
      held_q <= held_d;
    end
  end

  assign press_o = rise_o | rep_q;
  assign held_o  = held_q;
`else
  assign press_o = rise_o;
  assign held_o  = 1'b0;
`endif

endmodule

// File: rtl/btn_conditioner.sv
// N-channel button/mouse-level conditioner. Each bit of in_i gets its own
// btn_channel; any_rise_o flags a new press on any channel.
// Define BTN_CONDITIONER_AUTOREPEAT_EN to add long-press auto-repeat.
module btn_conditioner
  import btn_conditioner_pkg::*;
#(
  parameter int unsigned N          = 4,
  parameter int unsigned DB_CYCLES  = DB_CYCLES_DEFAULT,
  parameter bit          ACTIVE_LOW = 1'b0
`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
  ,
  parameter int unsigned HOLD_CYCLES   = HOLD_CYCLES_DEFAULT,
  parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEFAULT
`endif
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in_i,
  output logic [N-1:0] level_o,
  output logic [N-1:0] rise_o,
  output logic [N-1:0] fall_o,
  output logic [N-1:0] press_o,
  output logic [N-1:0] held_o,
  output logic         any_rise_o
);

  for (genvar i = 0; i < N; i++) begin : g_ch
    btn_channel #(
      .DB_CYCLES    (DB_CYCLES),
      .ACTIVE_LOW   (ACTIVE_LOW)
`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
      ,
      .HOLD_CYCLES  (HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
`endif
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .in_i   (in_i[i]),
      .level_o(level_o[i]),
      .rise_o (rise_o[i]),
      .fall_o (fall_o[i]),
      .press_o(press_o[i]),
      .held_o (held_o[i])
    );
  end

  assign any_rise_o = |rise_o;

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner (N=4, DB_CYCLES=4, HOLD=20, REPEAT=8).
// Expected outputs are queued with a due cycle when stimulus is applied and
// compared on the falling edge of that cycle.
module tb_btn_conditioner;

  localparam int N       = 4;
  localparam int DB      = 4;
  localparam int HOLD_TB = 20;
  localparam int REP_TB  = 8;
`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
  localparam bit FEAT = 1'b1;
`else
  localparam bit FEAT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] in_v, in_al;
  logic [N-1:0] level_o, rise_o, fall_o, press_o, held_o;
  logic         any_rise_o;
  logic [N-1:0] al_level, al_rise, al_fall, al_press, al_held;
  logic         al_any;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  btn_conditioner #(
    .N(N), .DB_CYCLES(DB), .ACTIVE_LOW(1'b0)
`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
    , .HOLD_CYCLES(HOLD_TB), .REPEAT_CYCLES(REP_TB)
`endif
  ) dut (
    .clk(clk), .rst(rst), .in_i(in_v),
    .level_o(level_o), .rise_o(rise_o), .fall_o(fall_o),
    .press_o(press_o), .held_o(held_o), .any_rise_o(any_rise_o)
  );

  btn_conditioner #(
    .N(N), .DB_CYCLES(DB), .ACTIVE_LOW(1'b1)
`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
    , .HOLD_CYCLES(HOLD_TB), .REPEAT_CYCLES(REP_TB)
`endif
  ) dut_al (
    .clk(clk), .rst(rst), .in_i(in_al),
    .level_o(al_level), .rise_o(al_rise), .fall_o(al_fall),
    .press_o(al_press), .held_o(al_held), .any_rise_o(al_any)
  );

  typedef struct {
    int         due;
    string      name;
    logic [3:0] level, rise, fall, press, held;
    logic       any_rise;
    logic [3:0] al_level;
  } exp_t;

  typedef struct {
    string      name;
    logic [3:0] in_v, old_l, new_l, hb;
    int         first, from_dt, to_dt, dwell;
  } row_t;

  exp_t exp_q[$];
  row_t rows[4];
  int   checks = 0;
  int   errors = 0;

  task automatic push_rec(input int dt, input string nm,
                          input logic [3:0] l, input logic [3:0] r,
                          input logic [3:0] f, input logic [3:0] p,
                          input logic [3:0] h, input logic [3:0] al);
    exp_t e;
    e.due = cyc + dt;  e.name = nm;
    e.level = l;  e.rise = r;  e.fall = f;  e.press = p;  e.held = h;
    e.any_rise = |r;  e.al_level = al;
    exp_q.push_back(e);
  endtask

  // Level steps from old_l to new_l in cycle 'first' after the input change.
  task automatic expect_window(input string nm, input int from_dt, input int to_dt,
                               input int first, input logic [3:0] old_l,
                               input logic [3:0] new_l, input logic [3:0] hb);
    for (int dt = from_dt; dt <= to_dt; dt++) begin
      logic [3:0] l, r, f, h;
      l = (dt >= first) ? new_l : old_l;
      r = (dt == first) ? (new_l & ~old_l) : 4'b0000;
      f = (dt == first) ? (old_l & ~new_l) : 4'b0000;
      h = (dt < first) ? hb : 4'b0000;
      push_rec(dt, nm, l, r, f, r, h, 4'b0000);
    end
  endtask

  task automatic check_due();
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].due <= cyc) begin
        exp_t e;
        e = exp_q[i];
        checks++;
        if (e.due != cyc || level_o !== e.level || rise_o !== e.rise ||
            fall_o !== e.fall || press_o !== e.press || held_o !== e.held ||
            any_rise_o !== e.any_rise || al_level !== e.al_level) begin
          errors++;
          $display("FAIL %s cyc=%0d: got lvl=%b rise=%b fall=%b press=%b held=%b any=%b al=%b; expected lvl=%b rise=%b fall=%b press=%b held=%b any=%b al=%b (due %0d)",
                   e.name, cyc, level_o, rise_o, fall_o, press_o, held_o, any_rise_o, al_level,
                   e.level, e.rise, e.fall, e.press, e.held, e.any_rise, e.al_level, e.due);
        end
        exp_q.delete(i);
      end
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      check_due();
    end
  endtask

  initial begin
    rows[0] = '{name:"ch0_rise",  in_v:4'b0001, old_l:4'b0000, new_l:4'b0001, hb:4'b0000,
                first:6, from_dt:1, to_dt:8, dwell:10};
    rows[1] = '{name:"ch0_fall",  in_v:4'b0000, old_l:4'b0001, new_l:4'b0000, hb:4'b0000,
                first:6, from_dt:1, to_dt:7, dwell:8};
    rows[2] = '{name:"ch23_rise", in_v:4'b1100, old_l:4'b0000, new_l:4'b1100, hb:4'b0000,
                first:6, from_dt:1, to_dt:8, dwell:30};
    rows[3] = '{name:"ch23_fall", in_v:4'b0000, old_l:4'b1100, new_l:4'b0000,
                hb:(FEAT ? 4'b1100 : 4'b0000), first:6, from_dt:5, to_dt:7, dwell:8};

    // Reset, inputs idle (active-low instance sees all released as 1111).
    rst = 1'b1;  in_v = 4'b0000;  in_al = 4'b1111;
    wait_cyc(1);
    push_rec(1, "in_reset", 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0);
    wait_cyc(1);
    rst = 1'b0;
    expect_window("after_reset", 1, 10, 99, 4'b0000, 4'b0000, 4'b0000);
    wait_cyc(10);

    // Clean steps from the vector table.
    for (int i = 0; i < 4; i++) begin
      in_v = rows[i].in_v;
      expect_window(rows[i].name, rows[i].from_dt, rows[i].to_dt, rows[i].first,
                    rows[i].old_l, rows[i].new_l, rows[i].hb);
      wait_cyc(rows[i].dwell);
    end

    // 3-cycle glitch on ch1 must be rejected.
    in_v = 4'b0010;
    expect_window("glitch3", 1, 14, 99, 4'b0000, 4'b0000, 4'b0000);
    wait_cyc(3);
    in_v = 4'b0000;
    wait_cyc(11);

    // 3 high, 1 low, 4+ high: only the final run is accepted.
    in_v = 4'b0010;
    expect_window("glitch_3_1_4", 1, 12, 10, 4'b0000, 4'b0010, 4'b0000);
    wait_cyc(3);
    in_v = 4'b0000;
    wait_cyc(1);
    in_v = 4'b0010;
    wait_cyc(8);
    in_v = 4'b0000;
    expect_window("glitch_release", 1, 7, 6, 4'b0010, 4'b0000, 4'b0000);
    wait_cyc(8);

    // Long press on ch0: repeats at rise+20, +28, ... when the feature is built in.
    in_v = 4'b0001;
    for (int dt = 1; dt <= 66; dt++) begin
      logic [3:0] r, p, h;
      logic       rep;
      r   = (dt == 6) ? 4'b0001 : 4'b0000;
      rep = FEAT && (dt >= 6 + HOLD_TB) && (((dt - 6 - HOLD_TB) % REP_TB) == 0);
      p   = r | {3'b000, rep};
      h   = (FEAT && dt >= 6 + HOLD_TB) ? 4'b0001 : 4'b0000;
      push_rec(dt, "hold_repeat", (dt >= 6) ? 4'b0001 : 4'b0000, r, 4'b0000, p, h, 4'b0000);
    end
    wait_cyc(66);
    in_v = 4'b0000;
    for (int dt = 1; dt <= 9; dt++) begin
      logic [3:0] l, f, h;
      l = (dt < 6) ? 4'b0001 : 4'b0000;
      f = (dt == 6) ? 4'b0001 : 4'b0000;
      h = (FEAT && dt < 6) ? 4'b0001 : 4'b0000;
      push_rec(dt, "hold_release", l, 4'b0000, f, 4'b0000, h, 4'b0000);
    end
    wait_cyc(10);

    // Reset mid-debounce discards the partial count.
    in_v = 4'b0001;
    expect_window("reset_mid_count", 1, 12, 11, 4'b0000, 4'b0001, 4'b0000);
    wait_cyc(4);
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    wait_cyc(7);
    in_v = 4'b0000;
    expect_window("reset_release", 1, 7, 6, 4'b0001, 4'b0000, 4'b0000);
    wait_cyc(8);

    // Active-low instance: driving ch0 low is a press.
    in_al = 4'b1110;
    for (int dt = 1; dt <= 8; dt++)
      push_rec(dt, "active_low", 4'b0, 4'b0, 4'b0, 4'b0, 4'b0,
               (dt >= 6) ? 4'b0001 : 4'b0000);
    wait_cyc(8);

    for (int k = 0; k < 50 && exp_q.size() > 0; k++) wait_cyc(1);
    while (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s never checked: due cyc %0d, now %0d", exp_q[0].name, exp_q[0].due, cyc);
      void'(exp_q.pop_front());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
